// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default bus widths and the arbiter state
// encoding, kept here so later arbiters can reuse them.
package wb_pkg;

    // Default address and data widths of the on-chip Wishbone bus.
    localparam int WB_AW = 11;
    localparam int WB_DW = 32;

    // Arbiter ownership states: nobody, master 0 or master 1 owns the slave.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // One-hot grant vector for a given ownership state (bit 0 = master 0).
    function automatic logic [1:0] grant_of(input arb_state_t state);
        logic [1:0] grant;
        grant = 2'b00;
        case (state)
            OWN0:    grant = 2'b01;
            OWN1:    grant = 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Per-transfer watchdog for the Wishbone arbiter. Counts consecutive cycles
// in which the bus owner strobes but the slave answers with neither ack nor
// err, and fires for one cycle when the count reaches TIMEOUT.
// TIMEOUT = 0 disables the watchdog entirely.
module wb_watchdog
#(
    parameter int TIMEOUT = 15
)
(
    input  logic clk_i,
    input  logic reset_ni,
    input  logic stall,
    output logic fire
);

    // A zero timeout would give a zero-width counter, so keep at least one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit ENABLED = (TIMEOUT != 0);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Fire exactly when the stall count has reached the limit.
    assign fire = ENABLED && (cnt == LIMIT);

    // Stall counter: clears on any cycle that is not a stalled strobe
    // (ack, err, strobe low, or ownership change) and right after firing,
    // so a persisting stall fires again only after another full interval.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt <= '0;
        end else if (!ENABLED || !stall || fire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone classic arbiter in front of a single
// slave. The grant is held for a whole cyc burst, ties are broken against
// the most recently granted master, and a watchdog terminates transfers
// the slave never answers by returning err to the owner.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 15
)
(
    input  logic            clk_i,
    input  logic            reset_ni,

    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_data_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_data_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [DW-1:0]   m_data_o,

    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_data_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic [DW-1:0]   s_data_i,

    output logic [1:0]      grant_o
);

    arb_state_t state;
    logic       last;
    logic       owner_cyc;
    logic       owner_stb;
    logic       stall;
    logic       wd_fire;

    // Grant FSM. last remembers the most recent grant so a tie goes to the
    // other master; it starts at 1 so master 0 wins the first tie. The owner
    // keeps the bus as long as it holds cyc; when it lets go, a waiting
    // master takes over directly without passing through IDLE.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= IDLE;
            last    <= 1'b1;
            grant_o <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (last) begin
                            state   <= OWN0;
                            last    <= 1'b0;
                            grant_o <= grant_of(OWN0);
                        end else begin
                            state   <= OWN1;
                            last    <= 1'b1;
                            grant_o <= grant_of(OWN1);
                        end
                    end else if (m0_cyc_i) begin
                        state   <= OWN0;
                        last    <= 1'b0;
                        grant_o <= grant_of(OWN0);
                    end else if (m1_cyc_i) begin
                        state   <= OWN1;
                        last    <= 1'b1;
                        grant_o <= grant_of(OWN1);
                    end
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            state   <= OWN1;
                            last    <= 1'b1;
                            grant_o <= grant_of(OWN1);
                        end else begin
                            state   <= IDLE;
                            grant_o <= grant_of(IDLE);
                        end
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            state   <= OWN0;
                            last    <= 1'b0;
                            grant_o <= grant_of(OWN0);
                        end else begin
                            state   <= IDLE;
                            grant_o <= grant_of(IDLE);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= grant_of(IDLE);
                end
            endcase
        end
    end

    // Read data is broadcast to both masters; only the owner sees an ack.
    assign m_data_o = s_data_i;

    // Bus mux: route the owner's request to the slave and the slave's
    // response back to the owner only. Strobe is withheld from the slave in
    // the watchdog fire cycle, so that cycle ends the transfer with err.
    always_comb begin
        s_addr_o  = '0;
        s_data_o  = '0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        case (state)
            OWN0: begin
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i & ~wd_fire;
                m0_ack_o  = s_ack_i;
                m0_err_o  = s_err_i | wd_fire;
                owner_cyc = m0_cyc_i;
                owner_stb = m0_stb_i;
            end
            OWN1: begin
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i & ~wd_fire;
                m1_ack_o  = s_ack_i;
                m1_err_o  = s_err_i | wd_fire;
                owner_cyc = m1_cyc_i;
                owner_stb = m1_stb_i;
            end
            default: begin
            end
        endcase
    end

    // A stalled cycle is an owner strobe with no slave response. Ownership
    // only changes after the owner drops cyc, and that cycle is never a
    // stall, so the watchdog also restarts on every state change.
    assign stall = owner_cyc & owner_stb & ~s_ack_i & ~s_err_i;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .stall    (stall),
        .fire     (wd_fire)
    );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a behavioural RAM slave with switchable
// ack/err, a reference memory feeding a queue of expected read data, and a
// second arbiter instance with the watchdog disabled.
module tb_wb_arbiter2;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;

    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_data, m1_data;
    logic          m0_we, m1_we;
    logic [SW-1:0] m0_sel, m1_sel;
    logic          m0_cyc, m1_cyc, m0_stb, m1_stb;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m_data;

    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          s_we, s_cyc, s_stb, s_ack, s_err;
    logic [SW-1:0] s_sel;
    logic [1:0]    grant;

    logic          z_m0_ack, z_m1_ack, z_m0_err, z_m1_err;
    logic [DW-1:0] z_m_data, z_s_wdata;
    logic [AW-1:0] z_s_addr;
    logic          z_s_we, z_s_cyc, z_s_stb;
    logic [SW-1:0] z_s_sel;
    logic [1:0]    z_grant;

    logic          ack_en;
    logic          err_en;
    logic [DW-1:0] mem     [0:2047];
    logic [DW-1:0] ref_mem [0:2047];
    logic [DW-1:0] exp_q   [$];

    int            n_checks;
    int            n_fail;
    int            ack_count;
    int            z_err_count;

    always #5 clk = ~clk;

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m_data_o(m_data),
        .s_addr_o(s_addr), .s_data_o(s_wdata), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack), .s_err_i(s_err),
        .s_data_i(s_rdata), .grant_o(grant)
    );

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(0)) dut_nowd (
        .clk_i(clk), .reset_ni(reset_n),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err),
        .m_data_o(z_m_data),
        .s_addr_o(z_s_addr), .s_data_o(z_s_wdata), .s_we_o(z_s_we), .s_sel_o(z_s_sel),
        .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_ack_i(1'b0), .s_err_i(1'b0),
        .s_data_i(32'h0), .grant_o(z_grant)
    );

    // Single-cycle RAM slave: combinational ack/err/read data, write at the edge.
    assign s_ack   = s_cyc & s_stb & ack_en;
    assign s_err   = s_cyc & s_stb & err_en;
    assign s_rdata = mem[s_addr];

    always @(posedge clk) begin
        logic [DW-1:0] wtmp;
        if (s_cyc && s_stb && s_ack && s_we) begin
            wtmp = mem[s_addr];
            for (int b = 0; b < SW; b++) begin
                if (s_sel[b]) wtmp[8*b +: 8] = s_wdata[8*b +: 8];
            end
            mem[s_addr] <= wtmp;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One Wishbone transfer by master m, started at a drive point; returns
    // at the drive point after the completing edge with strobe dropped.
    task automatic applyStimulus(input int m, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [1:0] exp_grant);
        bit            got;
        logic          own_ack, other_ack;
        logic [DW-1:0] exp;
        if (m == 0) begin
            m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_addr = addr; m0_data = data; m0_sel = '1;
        end else begin
            m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_addr = addr; m1_data = data; m1_sel = '1;
        end
        if (we) ref_mem[addr] = data;
        else    exp_q.push_back(ref_mem[addr]);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            own_ack   = (m == 0) ? m0_ack : m1_ack;
            other_ack = (m == 0) ? m1_ack : m0_ack;
            checkOutput("grant_held", {30'b0, grant}, {30'b0, exp_grant});
            checkOutput("non_owner_ack", {31'b0, other_ack}, 32'h0);
            if (own_ack === 1'b1) begin
                got = 1'b1;
                ack_count++;
                if (!we && exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    checkOutput("read_data", m_data, exp);
                end
                break;
            end
            nextCycle();
        end
        checkOutput("ack_seen", {31'b0, got}, 32'h1);
        if (got) nextCycle();
        if (m == 0) m0_stb = 1'b0;
        else        m1_stb = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; ack_count = 0; z_err_count = 0;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[0] = 32'h0BAD_F00D;
        ref_mem[0] = 32'h0BAD_F00D;
        m0_addr = '0; m0_data = '0; m0_we = 1'b0; m0_sel = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_addr = '0; m1_data = '0; m1_we = 1'b0; m1_sel = '0; m1_cyc = 1'b0; m1_stb = 1'b0;
        ack_en = 1'b1; err_en = 1'b0;
        reset_n = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_grant", {30'b0, grant}, 32'h0);
        checkOutput("rst_s_cyc", {31'b0, s_cyc}, 32'h0);
        checkOutput("rst_s_stb", {31'b0, s_stb}, 32'h0);
        checkOutput("rst_s_addr", {21'b0, s_addr}, 32'h0);
        checkOutput("rst_m0_ack", {31'b0, m0_ack}, 32'h0);
        checkOutput("rst_m1_err", {31'b0, m1_err}, 32'h0);
        checkOutput("rst_m_data", m_data, 32'h0BAD_F00D);
        nextCycle();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_grant", {30'b0, grant}, 32'h0);

        // Single master write then read
        $display("[TB] single master write/read");
        nextCycle();
        m0_cyc = 1'b1;
        @(negedge clk);
        checkOutput("grant_before_edge", {30'b0, grant}, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("grant_m0", {30'b0, grant}, 32'h1);
        checkOutput("s_cyc_m0", {31'b0, s_cyc}, 32'h1);
        nextCycle();
        applyStimulus(0, 1'b1, 11'd5, 32'hDEAD_BEEF, 2'b01);
        applyStimulus(0, 1'b0, 11'd5, 32'h0, 2'b01);
        m0_cyc = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("release_idle", {30'b0, grant}, 32'h0);

        // Simultaneous requests straight out of reset
        $display("[TB] tie from reset and handoff");
        nextCycle();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        nextCycle();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("tie1_grant", {30'b0, grant}, 32'h1);
        nextCycle();
        applyStimulus(0, 1'b1, 11'd7, 32'hCAFE_F00D, 2'b01);
        m0_cyc = 1'b0;
        @(negedge clk);
        checkOutput("gap_s_cyc", {31'b0, s_cyc}, 32'h0);
        checkOutput("gap_grant", {30'b0, grant}, 32'h1);
        nextCycle();
        @(negedge clk);
        checkOutput("handoff_grant", {30'b0, grant}, 32'h2);
        checkOutput("handoff_s_cyc", {31'b0, s_cyc}, 32'h1);
        nextCycle();
        applyStimulus(1, 1'b0, 11'd7, 32'h0, 2'b10);
        m1_cyc = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("idle_after_m1", {30'b0, grant}, 32'h0);
        nextCycle();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("tie2_grant", {30'b0, grant}, 32'h1);
        nextCycle();
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("idle_after_tie2", {30'b0, grant}, 32'h0);

        // m1 holds the grant for ten transfers while m0 waits
        $display("[TB] held grant");
        nextCycle();
        m1_cyc = 1'b1;
        nextCycle();
        m0_cyc = 1'b1;
        @(negedge clk);
        checkOutput("held_grant_m1", {30'b0, grant}, 32'h2);
        nextCycle();
        ack_count = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 1'b1, 11'(20 + k), 32'h1000_0000 + 32'(k), 2'b10);
        end
        checkOutput("held_ack_count", 32'(ack_count), 32'd10);
        m1_cyc = 1'b0;
        @(negedge clk);
        checkOutput("held_gap_s_cyc", {31'b0, s_cyc}, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("held_then_m0", {30'b0, grant}, 32'h1);
        nextCycle();
        applyStimulus(0, 1'b0, 11'd25, 32'h0, 2'b01);
        err_en = 1'b1;
        m0_stb = 1'b1; m0_we = 1'b0;
        @(negedge clk);
        checkOutput("ack_err_ack", {31'b0, m0_ack}, 32'h1);
        checkOutput("ack_err_err", {31'b0, m0_err}, 32'h1);
        checkOutput("ack_err_other", {31'b0, m1_err}, 32'h0);
        nextCycle();
        err_en = 1'b0;
        m0_stb = 1'b0; m0_cyc = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("idle_before_wd", {30'b0, grant}, 32'h0);

        // Watchdog: slave never acks
        $display("[TB] watchdog");
        nextCycle();
        ack_en = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 11'd3;
        nextCycle();
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k <= 20) begin
                checkOutput($sformatf("wd_err_%0d", k), {31'b0, m0_err}, (k == 16) ? 32'h1 : 32'h0);
                checkOutput($sformatf("wd_stb_%0d", k), {31'b0, s_stb}, (k == 16) ? 32'h0 : 32'h1);
            end
            if (z_m0_err !== 1'b0) z_err_count++;
            nextCycle();
        end
        checkOutput("nowd_err_count", 32'(z_err_count), 32'h0);
        checkOutput("nowd_stb_held", {31'b0, z_s_stb}, 32'h1);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        nextCycle();

        // Reset in the middle of an m1 transfer
        $display("[TB] reset mid-transfer");
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = 11'd9;
        nextCycle();
        @(negedge clk);
        checkOutput("pre_rst_grant", {30'b0, grant}, 32'h2);
        checkOutput("pre_rst_stb", {31'b0, s_stb}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_s_cyc", {31'b0, s_cyc}, 32'h0);
        checkOutput("mid_rst_s_stb", {31'b0, s_stb}, 32'h0);
        checkOutput("mid_rst_grant", {30'b0, grant}, 32'h0);
        ack_en = 1'b1;
        #1;
        checkOutput("mid_rst_ack", {31'b0, m1_ack}, 32'h0);
        m1_stb = 1'b0;
        m0_cyc = 1'b1;
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("post_rst_tie", {30'b0, grant}, 32'h1);
        nextCycle();
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
